// File: rtl/bfcpu_pkg.sv
// bfcpu_pkg: shared loop-stack FSM state encoding and default sizes for the controller and its RAM
package bfcpu_pkg;
  localparam int I_ADDR_WIDTH = 16;
  localparam int MAX_LOOP_DEPTH = 32'h100;
  typedef enum logic {ST_IDLE, ST_REFILL} state_t;
endpackage

// File: rtl/loop_stack_ctrl.sv
// loop_stack_ctrl: loop stack with TOS held in a register and lower entries in an external sync-read RAM; push/pop in (qualified by ready), top/top_valid/depth/full/empty/sticky error flags out, ram_write_*/ram_read_addr out and ram_read_data in
module loop_stack_ctrl
  import bfcpu_pkg::*;
#(
  parameter int I_ADDR_WIDTH = bfcpu_pkg::I_ADDR_WIDTH,
  parameter int MAX_LOOP_DEPTH = bfcpu_pkg::MAX_LOOP_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [I_ADDR_WIDTH-1:0] push_data,
  input  logic                    pop,
  output logic                    ready,
  output logic [I_ADDR_WIDTH-1:0] top,
  output logic                    top_valid,
  output logic [31:0]             depth,
  output logic                    full,
  output logic                    empty,
  output logic                    err_overflow,
  output logic                    err_underflow,
  output logic [31:0]             ram_write_addr,
  output logic                    ram_write_en,
  output logic [I_ADDR_WIDTH-1:0] ram_write_data,
  output logic [31:0]             ram_read_addr,
  input  logic [I_ADDR_WIDTH-1:0] ram_read_data
);
  state_t state;
  assign ready = state == ST_IDLE;
  assign full = depth == 32'(MAX_LOOP_DEPTH);
  assign empty = depth == 32'd0;
  assign top_valid = ready && !empty;
  assign ram_write_en = ready && push && !pop && !full && !empty;
  assign ram_write_addr = depth - 32'd1;
  assign ram_write_data = top;
  assign ram_read_addr = depth - 32'd2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      depth <= '0;
      top <= '0;
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
    end else if (state == ST_REFILL) begin
      top <= ram_read_data;
      state <= ST_IDLE;
    end else if (push && !pop) begin
      if (full) err_overflow <= 1'b1;
      else begin
        top <= push_data;
        depth <= depth + 32'd1;
      end
    end else if (pop) begin
      if (empty) err_underflow <= 1'b1;
      else if (push) top <= push_data;
      else begin
        depth <= depth - 32'd1;
        state <= depth == 32'd1 ? ST_IDLE : ST_REFILL;
      end
    end
  end
endmodule

// File: tb/tb_loop_stack_ctrl.sv
// tb_loop_stack_ctrl: directed and random checks of loop_stack_ctrl against a queue-based stack model
module tb_loop_stack_ctrl;
  logic clk = 0;
  logic rst_n, push, pop;
  logic [15:0] push_data, top, ram_write_data, ram_read_data;
  logic ready, top_valid, full, empty, err_overflow, err_underflow, ram_write_en;
  logic [31:0] depth, ram_write_addr, ram_read_addr;
  logic [15:0] mem [0:3];
  int tests = 0, fails = 0;
  int q[$];
  bit pend, ovf, unf;
  always #5 clk = ~clk;
  loop_stack_ctrl #(.I_ADDR_WIDTH(16), .MAX_LOOP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
    .ready(ready), .top(top), .top_valid(top_valid), .depth(depth), .full(full),
    .empty(empty), .err_overflow(err_overflow), .err_underflow(err_underflow),
    .ram_write_addr(ram_write_addr), .ram_write_en(ram_write_en),
    .ram_write_data(ram_write_data), .ram_read_addr(ram_read_addr),
    .ram_read_data(ram_read_data)
  );
  always_ff @(posedge clk) begin
    if (ram_write_en) mem[ram_write_addr[1:0]] <= ram_write_data;
    ram_read_data <= mem[ram_read_addr[1:0]];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit r, input bit p, input bit o, input logic [15:0] d);
    bit rdy;
    rst_n = !r;
    push = p;
    pop = o;
    push_data = d;
    #1;
    rdy = !pend;
    chk("ready", 32'(ready), 32'(rdy));
    chk("depth", depth, q.size());
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 4));
    chk("top_valid", 32'(top_valid), 32'(rdy && q.size() != 0));
    if (rdy && q.size() != 0) chk("top", 32'(top), q[$]);
    chk("err_overflow", 32'(err_overflow), 32'(ovf));
    chk("err_underflow", 32'(err_underflow), 32'(unf));
    chk("ram_write_en", 32'(ram_write_en), 32'(rdy && p && !o && q.size() inside {[1:3]}));
    if (r) begin
      q.delete();
      pend = 0;
      ovf = 0;
      unf = 0;
    end else if (pend) pend = 0;
    else if (p && !o) begin
      if (q.size() == 4) ovf = 1;
      else q.push_back(d);
    end else if (o) begin
      if (q.size() == 0) unf = 1;
      else if (p) q[q.size()-1] = d;
      else begin
        void'(q.pop_back());
        pend = q.size() != 0;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 0;
    push = 0;
    pop = 0;
    push_data = 0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 0);
    step(0, 1, 0, 16'h0010);
    step(0, 1, 0, 16'h0020);
    step(0, 1, 0, 16'h0030);
    chk("ram0", 32'(mem[0]), 32'h0010);
    chk("ram1", 32'(mem[1]), 32'h0020);
    repeat (3) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 16'(i * 16'h0100));
    step(0, 1, 0, 16'h0050);
    step(0, 1, 1, 16'h0060);
    step(0, 0, 0, 0);
    repeat (4) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    step(0, 0, 1, 0);
    step(0, 1, 1, 16'h0077);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 16'h0011);
    step(0, 1, 0, 16'h0022);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
